// File: rtl/mem_access.sv
// mem_access: MEM stage of the 5-stage MIPS pipeline.
// Runs loads/stores as req/ack data-bus transactions with big-endian byte lanes.
module mem_access #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mem_op,
    input  logic [31:0] result,
    input  logic [31:0] store_data,
    input  logic        en_wb,
    input  logic [4:0]  desReg_addr,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    input  logic        mem_en_hilo_i,
    input  logic [5:0]  stop,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    output logic        stallreq_mem,
    output logic [31:0] result_o,
    output logic        en_wb_o,
    output logic [4:0]  desReg_addr_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        en_hilo_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;

    logic        is_load, is_store, sz_byte, sz_half, sz_word, ld_sext;
    logic        misalign, access;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        unused_stop;

    assign unused_stop = ^{stop[5:4], stop[2:0]};

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_byte  = 1'b0;
        sz_half  = 1'b0;
        sz_word  = 1'b0;
        ld_sext  = 1'b0;
        case (mem_op)
            4'd1: begin is_load  = 1'b1; sz_byte = 1'b1; ld_sext = 1'b1; end
            4'd2: begin is_load  = 1'b1; sz_byte = 1'b1; end
            4'd3: begin is_load  = 1'b1; sz_half = 1'b1; ld_sext = 1'b1; end
            4'd4: begin is_load  = 1'b1; sz_half = 1'b1; end
            4'd5: begin is_load  = 1'b1; sz_word = 1'b1; end
            4'd6: begin is_store = 1'b1; sz_byte = 1'b1; end
            4'd7: begin is_store = 1'b1; sz_half = 1'b1; end
            4'd8: begin is_store = 1'b1; sz_word = 1'b1; end
            default: ;
        endcase
    end

    assign misalign   = (sz_half & result[0]) | (sz_word & (result[1:0] != 2'b00));
    assign access     = (is_load | is_store) & ~misalign;
    assign misalign_o = misalign;

    // Big-endian: byte offset 0 lives on lane 3 (bits 31:24).
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        if (sz_byte) begin
            st_be    = 4'b1000 >> result[1:0];
            st_wdata = {4{store_data[7:0]}};
        end else if (sz_half) begin
            st_be    = result[1] ? 4'b0011 : 4'b1100;
            st_wdata = {2{store_data[15:0]}};
        end
    end

    always_comb begin
        case (result[1:0])
            2'd0:    ld_byte = rdata_q[31:24];
            2'd1:    ld_byte = rdata_q[23:16];
            2'd2:    ld_byte = rdata_q[15:8];
            default: ld_byte = rdata_q[7:0];
        endcase
        ld_half = result[1] ? rdata_q[15:0] : rdata_q[31:16];
        if (sz_byte)
            ld_ext = {{24{ld_sext & ld_byte[7]}}, ld_byte};
        else if (sz_half)
            ld_ext = {{16{ld_sext & ld_half[15]}}, ld_half};
        else
            ld_ext = rdata_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;

        stallreq_mem  = 1'b0;
        result_o      = result;
        en_wb_o       = en_wb & ~misalign;
        en_hilo_o     = mem_en_hilo_i;
        bus_err_o     = 1'b0;
        desReg_addr_o = desReg_addr;
        hi_o          = mem_hi_i;
        lo_o          = mem_lo_i;

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    stallreq_mem = 1'b1;
                    en_wb_o      = 1'b0;
                    en_hilo_o    = 1'b0;
                    state_d      = S_BUSY;
                    cnt_d        = '0;
                    req_d        = 1'b1;
                    we_d         = is_store;
                    addr_d       = {result[31:2], 2'b00};
                    be_d         = is_store ? st_be : 4'b1111;
                    wdata_d      = is_store ? st_wdata : '0;
                end
            end
            S_BUSY: begin
                stallreq_mem = 1'b1;
                en_wb_o      = 1'b0;
                en_hilo_o    = 1'b0;
                if (dbus_ack) begin
                    rdata_d = dbus_rdata;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_DONE: begin
                bus_err_o = err_q;
                if (is_load) begin
                    result_o = ld_ext;
                    en_wb_o  = en_wb & ~err_q;
                end
                // Held here while ctrl stalls ex_mem so the access is not re-issued.
                if (!stop[3]) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_be    = be_q;
    assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: byte-level memory model vs. a word-bus responder.
module tb_mem_access;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  mem_op;
    logic [31:0] result, store_data;
    logic        en_wb;
    logic [4:0]  desReg_addr;
    logic [31:0] mem_hi_i, mem_lo_i;
    logic        mem_en_hilo_i;
    logic [5:0]  stop;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        stallreq_mem;
    logic [31:0] result_o, hi_o, lo_o;
    logic        en_wb_o, en_hilo_o, misalign_o, bus_err_o;
    logic [4:0]  desReg_addr_o;

    mem_access #(.ACK_TIMEOUT(TO), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_op(mem_op), .result(result),
        .store_data(store_data), .en_wb(en_wb), .desReg_addr(desReg_addr),
        .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i), .mem_en_hilo_i(mem_en_hilo_i),
        .stop(stop), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .stallreq_mem(stallreq_mem),
        .result_o(result_o), .en_wb_o(en_wb_o), .desReg_addr_o(desReg_addr_o),
        .hi_o(hi_o), .lo_o(lo_o), .en_hilo_o(en_hilo_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        chk_res;
        logic        en_wb;
        logic        hilo;
        logic        err;
        int          stall_len;
    } res_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_exp_t;

    res_exp_t    res_q[$];
    bus_exp_t    bus_q[$];
    logic [7:0]  ref_mem[64];
    logic [31:0] wmem[16];

    int checks = 0;
    int errors = 0;
    int req_rises = 0;
    int ack_delay = 0;
    bit no_ack = 1'b0;
    int inj_req = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        logic [31:0] w0;
        w0 = 32'h11F2_3344;
        if (i < 4) return w0[8*(3-i) +: 8];
        return 8'(i * 29 + 7);
    endfunction

    // Word-wide bus slave with its own storage, updated by byte enables.
    initial begin : responder
        int wait_cnt;
        int inj_seen;
        int idx;
        for (int w = 0; w < 16; w++)
            wmem[w] = {init_byte(4*w), init_byte(4*w+1), init_byte(4*w+2), init_byte(4*w+3)};
        dbus_ack = 1'b0;
        dbus_rdata = '0;
        wait_cnt = 0;
        inj_seen = 0;
        forever begin
            @(negedge clk);
            dbus_ack = 1'b0;
            if (inj_req != inj_seen) begin
                inj_seen = inj_req;
                dbus_ack = 1'b1;
                dbus_rdata = 32'hDEAD_BEEF;
            end else if (dbus_req && !no_ack) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    idx = int'(dbus_addr[5:2]);
                    if (dbus_we) begin
                        for (int i = 0; i < 4; i++)
                            if (dbus_be[i]) wmem[idx][8*i +: 8] = dbus_wdata[8*i +: 8];
                    end
                    dbus_rdata = wmem[idx];
                    dbus_ack = 1'b1;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : result_monitor
        int scnt;
        res_exp_t e;
        scnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                scnt = 0;
            end else if (stallreq_mem) begin
                scnt++;
            end else if (scnt > 0) begin
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: completion with no expected entry at %0t", $time);
                end else begin
                    e = res_q.pop_front();
                    if (e.chk_res) chk("result_o", result_o, e.res);
                    chk("en_wb_o", 32'(en_wb_o), 32'(e.en_wb));
                    chk("en_hilo_o", 32'(en_hilo_o), 32'(e.hilo));
                    chk("bus_err_o", 32'(bus_err_o), 32'(e.err));
                    chk("stall_len", 32'(scnt), 32'(e.stall_len));
                end
                scnt = 0;
            end
        end
    end

    initial begin : bus_monitor
        logic prev_req;
        bus_exp_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (dbus_req && !prev_req) begin
                req_rises++;
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: request with no expected access at %0t", $time);
                end else begin
                    e = bus_q.pop_front();
                    chk("dbus_addr", dbus_addr, e.addr);
                    chk("dbus_we", 32'(dbus_we), 32'(e.we));
                    chk("dbus_be", 32'(dbus_be), 32'(e.be));
                    if (e.chk_wdata) chk("dbus_wdata", dbus_wdata, e.wdata);
                end
            end
            prev_req = dbus_req;
        end
    end

    task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic ewb, input int delay, input bit noack, input int hold);
        res_exp_t r;
        bus_exp_t b;
        int a, nb, start_rises;
        bit ld, done;
        logic [31:0] v;
        logic [3:0] be;
        logic [4:0] dr;
        logic [31:0] hi, lo;
        logic hil;
        a  = int'(addr[5:0]);
        ld = (op <= 4'd5);
        nb = (op == 4'd1 || op == 4'd2 || op == 4'd6) ? 1 :
             (op == 4'd3 || op == 4'd4 || op == 4'd7) ? 2 : 4;
        be = '0;
        for (int k = 0; k < nb; k++) be[3 - ((a + k) % 4)] = 1'b1;
        b.addr = {addr[31:2], 2'b00};
        b.we = !ld;
        b.be = ld ? 4'hF : be;
        b.wdata = (nb == 1) ? {4{sd[7:0]}} : (nb == 2) ? {2{sd[15:0]}} : sd;
        b.chk_wdata = !ld;
        v = '0;
        if (ld) begin
            for (int k = 0; k < nb; k++) v = (v << 8) | 32'(ref_mem[a + k]);
            if (op == 4'd1 && v[7])  v = v | 32'hFFFF_FF00;
            if (op == 4'd3 && v[15]) v = v | 32'hFFFF_0000;
        end else if (!noack) begin
            for (int k = 0; k < nb; k++) ref_mem[a + k] = sd[8*(nb-1-k) +: 8];
        end
        hil = 1'($urandom_range(0, 1));
        dr  = 5'($urandom());
        hi  = $urandom();
        lo  = $urandom();
        r.res = ld ? v : addr;
        r.chk_res = !(ld && noack);
        r.en_wb = ld ? (ewb & !noack) : ewb;
        r.hilo = hil;
        r.err = noack;
        r.stall_len = noack ? int'(TO) + 1 : delay + 2;
        res_q.push_back(r);
        bus_q.push_back(b);
        ack_delay = delay;
        no_ack = noack;
        start_rises = req_rises;
        mem_op = op; result = addr; store_data = sd; en_wb = ewb;
        desReg_addr = dr; mem_hi_i = hi; mem_lo_i = lo; mem_en_hilo_i = hil;
        stop = (hold > 0) ? 6'b001000 : 6'b000000;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (!stallreq_mem) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: op %0d never completed", op);
        end else begin
            chk("desReg_addr_o", 32'(desReg_addr_o), 32'(dr));
            chk("hi_o", hi_o, hi);
            chk("lo_o", lo_o, lo);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_stall", 32'(stallreq_mem), 32'd0);
            chk("hold_req", 32'(dbus_req), 32'd0);
            if (r.chk_res) chk("hold_result", result_o, r.res);
        end
        if (hold > 0) begin
            chk("single_request", 32'(req_rises - start_rises), 32'd1);
            @(posedge clk); #1;
            stop = '0;
        end
        @(posedge clk); #1;
        mem_op = '0;
        no_ack = 1'b0;
    endtask

    task automatic do_plain(input logic [3:0] op, input logic [31:0] addr);
        logic mis, ewb, hil;
        logic [4:0] dr;
        logic [31:0] hi, lo;
        mis = ((op == 4'd3 || op == 4'd4 || op == 4'd7) && addr[0]) ||
              ((op == 4'd5 || op == 4'd8) && (addr[1:0] != 2'b00));
        ewb = 1'($urandom_range(0, 1));
        hil = 1'($urandom_range(0, 1));
        dr = 5'($urandom());
        hi = $urandom();
        lo = $urandom();
        mem_op = op; result = addr; store_data = $urandom(); en_wb = ewb;
        desReg_addr = dr; mem_hi_i = hi; mem_lo_i = lo; mem_en_hilo_i = hil; stop = '0;
        @(negedge clk);
        chk("misalign_o", 32'(misalign_o), 32'(mis));
        chk("plain_stall", 32'(stallreq_mem), 32'd0);
        chk("plain_result", result_o, addr);
        chk("plain_en_wb", 32'(en_wb_o), 32'(ewb & !mis));
        chk("plain_en_hilo", 32'(en_hilo_o), 32'(hil));
        chk("plain_desreg", 32'(desReg_addr_o), 32'(dr));
        chk("plain_hi", hi_o, hi);
        chk("plain_lo", lo_o, lo);
        @(negedge clk);
        chk("plain_no_req", 32'(dbus_req), 32'd0);
        @(posedge clk); #1;
        mem_op = '0;
    endtask

    initial begin : stimulus
        logic [3:0] op;
        logic [31:0] addr;
        int a, sel;
        bit got;
        bus_exp_t b;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);
        rst_n = 1'b0;
        mem_op = '0; result = '0; store_data = '0; en_wb = 1'b0; desReg_addr = '0;
        mem_hi_i = '0; mem_lo_i = '0; mem_en_hilo_i = 1'b0; stop = '0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(dbus_req), 32'd0);
        chk("rst_we", 32'(dbus_we), 32'd0);
        chk("rst_addr", dbus_addr, 32'd0);
        chk("rst_be", 32'(dbus_be), 32'd0);
        chk("rst_wdata", dbus_wdata, 32'd0);
        chk("rst_stall", 32'(stallreq_mem), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_mem(4'd1, 32'h0000_1001, 32'h0, 1'b1, 1, 1'b0, 0);
        do_mem(4'd2, 32'h0000_1001, 32'h0, 1'b1, 1, 1'b0, 0);
        do_mem(4'd4, 32'h0000_1002, 32'h0, 1'b1, 0, 1'b0, 0);
        do_mem(4'd6, 32'h0000_2003, 32'h0000_00AB, 1'b0, 2, 1'b0, 0);
        do_mem(4'd7, 32'h0000_2002, 32'h1234_5678, 1'b0, 0, 1'b0, 0);
        do_mem(4'd5, 32'h0000_1000, 32'h0, 1'b1, 0, 1'b0, 0);
        do_plain(4'd5, 32'h0000_3002);
        do_mem(4'd5, 32'h0000_1004, 32'h0, 1'b1, 0, 1'b1, 0);
        do_mem(4'd5, 32'h0000_1008, 32'h0, 1'b1, 1, 1'b0, 2);

        // Reset while the access is outstanding; the late ack must be ignored.
        b.addr = 32'h0000_1010; b.we = 1'b0; b.be = 4'hF; b.wdata = '0; b.chk_wdata = 1'b0;
        bus_q.push_back(b);
        no_ack = 1'b1;
        mem_op = 4'd5; result = 32'h0000_1010; en_wb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (dbus_req) got = 1'b1;
        end
        chk("req_before_reset", 32'(dbus_req), 32'd1);
        #2;
        rst_n = 1'b0;
        mem_op = '0;
        #1;
        chk("async_rst_req", 32'(dbus_req), 32'd0);
        chk("async_rst_addr", dbus_addr, 32'd0);
        chk("async_rst_be", 32'(dbus_be), 32'd0);
        chk("async_rst_we", 32'(dbus_we), 32'd0);
        chk("async_rst_wdata", dbus_wdata, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        inj_req++;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_req", 32'(dbus_req), 32'd0);
        chk("post_rst_stall", 32'(stallreq_mem), 32'd0);
        chk("post_rst_err", 32'(bus_err_o), 32'd0);
        no_ack = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            a = $urandom_range(0, 63);
            if (sel < 7) begin
                op = 4'($urandom_range(1, 8));
                if (op == 4'd3 || op == 4'd4 || op == 4'd7) a = a & ~1;
                if (op == 4'd5 || op == 4'd8) a = a & ~3;
                addr = ($urandom() & 32'hFFFF_FFC0) | 32'(a);
                do_mem(op, addr, $urandom(), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2), 1'b0, ($urandom_range(0, 7) == 0) ? 2 : 0);
            end else if (sel == 7) begin
                sel = $urandom_range(0, 4);
                op = (sel == 0) ? 4'd3 : (sel == 1) ? 4'd4 : (sel == 2) ? 4'd7 :
                     (sel == 3) ? 4'd5 : 4'd8;
                if (op == 4'd5 || op == 4'd8) a = (a & ~3) | $urandom_range(1, 3);
                else a = a | 1;
                addr = ($urandom() & 32'hFFFF_FFC0) | 32'(a);
                do_plain(op, addr);
            end else begin
                sel = $urandom_range(0, 7);
                op = (sel == 0) ? 4'd0 : 4'(8 + sel);
                do_plain(op, $urandom());
            end
        end

        repeat (5) @(negedge clk);
        chk("res_queue_drained", 32'(res_q.size()), 32'd0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
